ac_motor_vector_timing: RTL and testbench

AC_MOTOR_VECTOR_TIMING -- requirements
Module: AC_MOTOR_VECTOR_TIMING

---
 rtl/ac_motor_vector_timing_pkg.sv | 34 +++
 rtl/ac_motor_dwell_clamp.sv | 53 +++++
 rtl/ac_motor_vector_timing.sv | 191 +++++++++++++++++++
 tb/tb_ac_motor_vector_timing.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_motor_vector_timing_pkg.sv
// ----------------------------------------------------------------------------
// ac_motor_vector_timing_pkg
// Shared definitions for the space-vector dwell sequencer.
//   seg_e      : segment encoding within one PWM period
//                (ZERO_A, VEC1, VEC2, ZERO_B).
//   SECTOR_MAX : highest legal sector number; 6 and 7 are treated as errors.
//   CNT_W      : width of period counter and dwell values (PERIOD <= 4095).
//   seg_to_u   : one-hot {U_2, U_1, U_0} for a segment.
// ----------------------------------------------------------------------------
package ac_motor_vector_timing_pkg;

    typedef enum logic [1:0] {
        SEG_ZERO_A = 2'd0,
        SEG_VEC1   = 2'd1,
        SEG_VEC2   = 2'd2,
        SEG_ZERO_B = 2'd3
    } seg_e;

    localparam logic [2:0] SECTOR_MAX = 3'd5;
    localparam int         CNT_W      = 12;

    // Both zero segments drive the zero vector.
    function automatic logic [2:0] seg_to_u(input seg_e seg);
        logic [2:0] u;
        u = 3'b001;
        case (seg)
            SEG_VEC1: u = 3'b010;
            SEG_VEC2: u = 3'b100;
            default:  u = 3'b001;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/ac_motor_dwell_clamp.sv
// ----------------------------------------------------------------------------
// ac_motor_dwell_clamp
// Combinational clamp of a dwell pair against the PWM period, plus the
// zero-vector time and its leading half.
//   t1_i, t2_i : requested dwells of the first/second adjacent vector
//   t1a_o      : min(t1, PERIOD)
//   t2a_o      : min(t2, PERIOD - t1a)
//   t0_o       : PERIOD - t1a - t2a
//   a_o        : t0 >> 1 (leading zero segment; odd cycle goes to the tail)
//   sat_o      : either dwell was reduced
// ----------------------------------------------------------------------------
module ac_motor_dwell_clamp
    import ac_motor_vector_timing_pkg::*;
#(
    parameter int PERIOD = 1000,
    parameter int TW     = 12
) (
    input  logic [TW-1:0]    t1_i,
    input  logic [TW-1:0]    t2_i,
    output logic [CNT_W-1:0] t1a_o,
    output logic [CNT_W-1:0] t2a_o,
    output logic [CNT_W-1:0] t0_o,
    output logic [CNT_W-1:0] a_o,
    output logic             sat_o
);

    // Compare at the wider of the input and counter widths so that large
    // requests are never truncated before being clamped.
    localparam int         W = (TW > CNT_W) ? TW : CNT_W;
    localparam logic [W-1:0] P = W'(PERIOD);

    logic [W-1:0] t1w;
    logic [W-1:0] t2w;
    logic [W-1:0] t1a;
    logic [W-1:0] rem;
    logic [W-1:0] t2a;
    logic [W-1:0] t0;

    always_comb begin
        t1w   = W'(t1_i);
        t2w   = W'(t2_i);
        t1a   = (t1w > P) ? P : t1w;
        rem   = P - t1a;
        t2a   = (t2w > rem) ? rem : t2w;
        t0    = rem - t2a;
        sat_o = (t1w > P) || (t2w > rem);
        t1a_o = CNT_W'(t1a);
        t2a_o = CNT_W'(t2a);
        t0_o  = CNT_W'(t0);
        a_o   = CNT_W'(t0 >> 1);
    end

endmodule

// File: rtl/ac_motor_vector_timing.sv
// ----------------------------------------------------------------------------
// ac_motor_vector_timing
// Space-vector PWM dwell sequencer. A free-running counter defines a period
// of PERIOD cycles; each period plays ZERO_A, VEC1, VEC2, ZERO_B from the
// active {sector, T1, T2} set. New sets enter a one-entry shadow register and
// become active at the next counter wrap.
//   CLK, RST             : clock, synchronous active-high reset
//   IN_VALID / IN_READY  : set offer; accepted on IN_VALID && IN_READY.
//                          IN_READY is high while the shadow is empty and
//                          RST is low.
//   IN_SECTOR, IN_T1/T2  : offered sector and dwell times (cycles)
//   SECTOR               : active sector (0 for illegal sectors)
//   U_0, U_1, U_2        : one-hot zero / first / second vector select
//   PERIOD_START         : pulse on the first output cycle of each period
//   SAT, SECT_ERR        : active set was clamped / had sector 6 or 7
// All outputs except IN_READY are registered; the output seen after the
// clock edge at counter value k is the segment for position k.
// ----------------------------------------------------------------------------
module ac_motor_vector_timing
    import ac_motor_vector_timing_pkg::*;
#(
    parameter int PERIOD = 1000,
    parameter int TW     = 12
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [2:0]    IN_SECTOR,
    input  logic [TW-1:0] IN_T1,
    input  logic [TW-1:0] IN_T2,
    output logic [2:0]    SECTOR,
    output logic          U_0,
    output logic          U_1,
    output logic          U_2,
    output logic          PERIOD_START,
    output logic          SAT,
    output logic          SECT_ERR
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sh_full_q, sh_full_d;
    logic [2:0]       sh_sector_q, sh_sector_d;
    logic [TW-1:0]    sh_t1_q, sh_t1_d;
    logic [TW-1:0]    sh_t2_q, sh_t2_d;
    logic [2:0]       act_sector_q, act_sector_d;
    logic [TW-1:0]    act_t1_q, act_t1_d;
    logic [TW-1:0]    act_t2_q, act_t2_d;
    logic [2:0]       u_q, u_d;
    logic             pstart_q, pstart_d;
    logic [2:0]       sector_q, sector_d;
    logic             sat_q, sat_d;
    logic             err_q, err_d;

    logic             start;
    logic             load;
    logic             accept;
    logic             in_ready;
    logic [2:0]       cur_sector;
    logic [TW-1:0]    cur_t1;
    logic [TW-1:0]    cur_t2;
    logic             cur_err;
    logic [CNT_W-1:0] t1a, t2a, t0, a;
    logic             sat;
    logic [CNT_W-1:0] b2, b3;
    seg_e             seg;

    // The set that governs the current period: at the wrap cycle a full
    // shadow takes effect immediately so its first output cycle lines up
    // with PERIOD_START.
    assign start      = (cnt_q == '0);
    assign load       = start && sh_full_q;
    assign cur_sector = load ? sh_sector_q : act_sector_q;
    assign cur_t1     = load ? sh_t1_q : act_t1_q;
    assign cur_t2     = load ? sh_t2_q : act_t2_q;
    assign cur_err    = (cur_sector > SECTOR_MAX);

    // Accept only into an empty shadow; a set accepted in the wrap cycle
    // therefore waits a full period (no bypass to the active set).
    assign in_ready   = !sh_full_q && !RST;
    assign accept     = IN_VALID && in_ready;
    assign IN_READY   = in_ready;

    ac_motor_dwell_clamp #(
        .PERIOD (PERIOD),
        .TW     (TW)
    ) u_clamp (
        .t1_i  (cur_t1),
        .t2_i  (cur_t2),
        .t1a_o (t1a),
        .t2a_o (t2a),
        .t0_o  (t0),
        .a_o   (a),
        .sat_o (sat)
    );

    // Segment boundaries; zero-length segments collapse naturally because
    // consecutive boundaries are then equal. t0 only feeds the tail segment
    // implicitly (everything past b3).
    assign b2 = a + t1a;
    assign b3 = b2 + t2a;

    always_comb begin
        seg          = SEG_ZERO_A;
        cnt_d        = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        sh_full_d    = sh_full_q;
        sh_sector_d  = sh_sector_q;
        sh_t1_d      = sh_t1_q;
        sh_t2_d      = sh_t2_q;
        act_sector_d = cur_sector;
        act_t1_d     = cur_t1;
        act_t2_d     = cur_t2;
        sector_d     = sector_q;
        sat_d        = sat_q;
        err_d        = err_q;
        pstart_d     = start;

        if (load) begin
            sh_full_d = 1'b0;
        end
        if (accept) begin
            sh_full_d   = 1'b1;
            sh_sector_d = IN_SECTOR;
            sh_t1_d     = IN_T1;
            sh_t2_d     = IN_T2;
        end

        if (cur_err) begin
            seg = SEG_ZERO_A;
        end else if (cnt_q < a) begin
            seg = SEG_ZERO_A;
        end else if (cnt_q < b2) begin
            seg = SEG_VEC1;
        end else if (cnt_q < b3) begin
            seg = SEG_VEC2;
        end else begin
            seg = SEG_ZERO_B;
        end
        u_d = seg_to_u(seg);

        // Status outputs only move at the period boundary.
        if (start) begin
            sector_d = cur_err ? 3'd0 : cur_sector;
            sat_d    = sat;
            err_d    = cur_err;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q        <= '0;
            sh_full_q    <= 1'b0;
            sh_sector_q  <= '0;
            sh_t1_q      <= '0;
            sh_t2_q      <= '0;
            act_sector_q <= '0;
            act_t1_q     <= '0;
            act_t2_q     <= '0;
            u_q          <= 3'b001;
            pstart_q     <= 1'b0;
            sector_q     <= '0;
            sat_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sh_full_q    <= sh_full_d;
            sh_sector_q  <= sh_sector_d;
            sh_t1_q      <= sh_t1_d;
            sh_t2_q      <= sh_t2_d;
            act_sector_q <= act_sector_d;
            act_t1_q     <= act_t1_d;
            act_t2_q     <= act_t2_d;
            u_q          <= u_d;
            pstart_q     <= pstart_d;
            sector_q     <= sector_d;
            sat_q        <= sat_d;
            err_q        <= err_d;
        end
    end

    assign U_0          = u_q[0];
    assign U_1          = u_q[1];
    assign U_2          = u_q[2];
    assign PERIOD_START = pstart_q;
    assign SECTOR       = sector_q;
    assign SAT          = sat_q;
    assign SECT_ERR     = err_q;

endmodule

// File: tb/tb_ac_motor_vector_timing.sv
// ----------------------------------------------------------------------------
// tb_ac_motor_vector_timing
// Directed, table-driven bench for ac_motor_vector_timing at PERIOD=100.
// Each table row holds a set and the run lengths it must produce: leading
// U_0 run, U_1 cycles, U_2 cycles, trailing U_0 run. When both dwells are
// zero the whole period is one U_0 run and is counted as the leading run.
// ----------------------------------------------------------------------------
module tb_ac_motor_vector_timing;

    localparam int PER = 100;
    localparam int TW  = 12;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IN_VALID;
    logic          IN_READY;
    logic [2:0]    IN_SECTOR;
    logic [TW-1:0] IN_T1;
    logic [TW-1:0] IN_T2;
    logic [2:0]    SECTOR;
    logic          U_0, U_1, U_2;
    logic          PERIOD_START;
    logic          SAT;
    logic          SECT_ERR;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        int sector;
        int t1;
        int t2;
        int n_a;
        int n_1;
        int n_2;
        int n_b;
        int e_sector;
        int e_sat;
        int e_err;
    } vec_t;

    vec_t vecs[10];
    vec_t prev;
    vec_t reset_vec;
    vec_t vx;
    vec_t vy;

    ac_motor_vector_timing #(
        .PERIOD (PER),
        .TW     (TW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .IN_SECTOR    (IN_SECTOR),
        .IN_T1        (IN_T1),
        .IN_T2        (IN_T2),
        .SECTOR       (SECTOR),
        .U_0          (U_0),
        .U_1          (U_1),
        .U_2          (U_2),
        .PERIOD_START (PERIOD_START),
        .SAT          (SAT),
        .SECT_ERR     (SECT_ERR)
    );

    // Clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input int sector, input int t1, input int t2,
                                input int n_a, input int n_1, input int n_2,
                                input int n_b, input int e_sector,
                                input int e_sat, input int e_err);
        vec_t v;
        v.sector = sector; v.t1 = t1; v.t2 = t2;
        v.n_a = n_a; v.n_1 = n_1; v.n_2 = n_2; v.n_b = n_b;
        v.e_sector = e_sector; v.e_sat = e_sat; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Driver
    task automatic drive_set(input vec_t v);
        IN_VALID  = 1'b1;
        IN_SECTOR = 3'(v.sector);
        IN_T1     = TW'(v.t1);
        IN_T2     = TW'(v.t2);
    endtask

    // Advance to the next sampled PERIOD_START (bounded).
    task automatic wait_pstart(input string tag);
        int found;
        found = 0;
        for (int k = 0; k < 2 * PER; k++) begin
            @(negedge CLK);
            if (PERIOD_START === 1'b1) begin
                found = 1;
                break;
            end
        end
        check($sformatf("%s_pstart_seen", tag), found, 1);
    endtask

    // Scoreboard for one period, starting at the PERIOD_START sample.
    // IN_VALID is dropped after the first clock edge of the period.
    task automatic capture(input vec_t e, input bit offered, input string tag);
        int na, n1, n2, nb, phase, shape_err, ready_err;
        int sec0, sat0, err0;
        na = 0; n1 = 0; n2 = 0; nb = 0; phase = 0;
        shape_err = 0; ready_err = 0;
        sec0 = 0; sat0 = 0; err0 = 0;
        for (int i = 0; i < PER; i++) begin
            if (i == 0) begin
                sec0 = int'(SECTOR);
                sat0 = int'(SAT);
                err0 = int'(SECT_ERR);
            end else begin
                if (int'(SECTOR) != sec0 || int'(SAT) != sat0 ||
                    int'(SECT_ERR) != err0) shape_err++;
                if (PERIOD_START !== 1'b0) shape_err++;
                if (offered && IN_READY !== 1'b0) ready_err++;
            end
            if ({U_2, U_1, U_0} === 3'b001) begin
                if (phase == 0) na++;
                else begin
                    phase = 3;
                    nb++;
                end
            end else if ({U_2, U_1, U_0} === 3'b010) begin
                if (phase > 1) shape_err++;
                phase = 1;
                n1++;
            end else if ({U_2, U_1, U_0} === 3'b100) begin
                if (phase > 2) shape_err++;
                phase = 2;
                n2++;
            end else begin
                shape_err++;
            end
            if (i < PER - 1) begin
                @(negedge CLK);
                if (i == 0) IN_VALID = 1'b0;
            end
        end
        check($sformatf("%s_zero_a", tag), na, e.n_a);
        check($sformatf("%s_vec1", tag), n1, e.n_1);
        check($sformatf("%s_vec2", tag), n2, e.n_2);
        check($sformatf("%s_zero_b", tag), nb, e.n_b);
        check($sformatf("%s_sector", tag), sec0, e.e_sector);
        check($sformatf("%s_sat", tag), sat0, e.e_sat);
        check($sformatf("%s_sect_err", tag), err0, e.e_err);
        check($sformatf("%s_shape", tag), shape_err, 0);
        if (offered) check($sformatf("%s_ready_low", tag), ready_err, 0);
    endtask

    initial begin
        int ready_hi;

        //           sec  t1    t2    n_a n_1  n_2 n_b sec sat err
        vecs[0] = mk(2,   30,   20,   25, 30,  20, 25, 2,  0,  0);
        vecs[1] = mk(1,   30,   21,   24, 30,  21, 25, 1,  0,  0);
        vecs[2] = mk(3,   80,   50,    0, 80,  20,  0, 3,  1,  0);
        vecs[3] = mk(7,   10,    0,  100,  0,   0,  0, 0,  0,  1);
        vecs[4] = mk(5,    0,    0,  100,  0,   0,  0, 5,  0,  0);
        vecs[5] = mk(0,  100,    0,    0,100,   0,  0, 0,  0,  0);
        vecs[6] = mk(4, 4095, 4095,    0,100,   0,  0, 4,  1,  0);
        vecs[7] = mk(6,    0,    0,  100,  0,   0,  0, 0,  0,  1);
        vecs[8] = mk(1,    0,   99,    0,  0,  99,  1, 1,  0,  0);
        vecs[9] = mk(2,    1,    0,   49,  1,   0, 50, 2,  0,  0);
        reset_vec = mk(0, 0, 0, 100, 0, 0, 0, 0, 0, 0);
        vx = mk(3, 10, 10, 40, 10, 10, 40, 3, 0, 0);
        vy = mk(4, 20, 40, 20, 20, 40, 20, 4, 0, 0);

        // Reset
        RST = 1'b1; IN_VALID = 1'b0; IN_SECTOR = '0; IN_T1 = '0; IN_T2 = '0;
        repeat (3) @(negedge CLK);
        check("reset_u0", int'(U_0), 1);
        check("reset_u1u2", int'({U_2, U_1}), 0);
        check("reset_pstart", int'(PERIOD_START), 0);
        check("reset_flags", int'({SECTOR, SAT, SECT_ERR}), 0);
        check("reset_ready", int'(IN_READY), 0);
        RST = 1'b0;
        @(negedge CLK);
        check("reset_first_pstart", int'(PERIOD_START), 1);
        capture(reset_vec, 1'b0, "reset_period");
        prev = reset_vec;

        // Table: offer in one period (which still plays the previous set),
        // then expect the new set over the following period.
        for (int v = 0; v < 10; v++) begin
            wait_pstart($sformatf("v%0d_offer", v));
            check($sformatf("v%0d_ready_offer", v), int'(IN_READY), 1);
            drive_set(vecs[v]);
            capture(prev, 1'b1, $sformatf("v%0d_reuse", v));
            wait_pstart($sformatf("v%0d_apply", v));
            capture(vecs[v], 1'b0, $sformatf("v%0d", v));
            prev = vecs[v];
        end

        // Two sets in one period: second is held off until the shadow drains.
        wait_pstart("two_set");
        check("two_set_ready_first", int'(IN_READY), 1);
        drive_set(vx);
        @(negedge CLK);
        drive_set(vy);
        ready_hi = 0;
        for (int k = 0; k < PER - 1; k++) begin
            if (IN_READY !== 1'b0) ready_hi++;
            @(negedge CLK);
        end
        check("two_set_ready_blocked", ready_hi, 0);
        check("two_set_wrap_pstart", int'(PERIOD_START), 1);
        check("two_set_ready_reopen", int'(IN_READY), 1);
        capture(vx, 1'b1, "two_set_first");
        wait_pstart("two_set_second");
        capture(vy, 1'b0, "two_set_second");

        // Reset in the middle of VEC1 (counter 40 of vecs[0]).
        wait_pstart("pre_rst");
        drive_set(vecs[0]);
        capture(vy, 1'b1, "pre_rst");
        wait_pstart("rst_period");
        repeat (39) @(negedge CLK);
        check("rst_in_vec1", int'(U_1), 1);
        RST = 1'b1;
        drive_set(vecs[1]);
        #1;
        check("rst_ready_low", int'(IN_READY), 0);
        @(negedge CLK);
        check("rst_u0", int'(U_0), 1);
        check("rst_u1u2", int'({U_2, U_1}), 0);
        check("rst_pstart", int'(PERIOD_START), 0);
        check("rst_flags", int'({SECTOR, SAT, SECT_ERR}), 0);
        RST = 1'b0;
        IN_VALID = 1'b0;
        @(negedge CLK);
        check("rst_first_pstart", int'(PERIOD_START), 1);
        capture(reset_vec, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
